// File: rtl/lane_index_renderer_pkg.sv
// rtl/lane_index_renderer_pkg.sv - lane code/colour tables, grade codes and shared types
package lane_render_pkg;

  localparam int LANE_TABLE_SIZE = 5;

  typedef logic [2:0] lane_code_t;

  localparam lane_code_t CODE_NONE = 3'b000;

  // Entry 0 is the leftmost lane: shake, left, up, down, right.
  localparam logic [LANE_TABLE_SIZE-1:0][2:0] LANE_CODE  = {3'b100, 3'b011, 3'b001, 3'b010, 3'b110};
  localparam logic [LANE_TABLE_SIZE-1:0][7:0] LANE_INDEX = {8'd5, 8'd7, 8'd6, 8'd4, 8'd8};

  localparam logic [7:0] DEFAULT_INDEX         = 8'd0;
  localparam logic [7:0] GRADE_INDEX_EXCELLENT = 8'd1;
  localparam logic [7:0] GRADE_INDEX_GOOD      = 8'd2;
  localparam logic [7:0] GRADE_INDEX_BAD       = 8'd3;

  typedef enum logic [1:0] {
    GRADE_NONE      = 2'b00,
    GRADE_BAD       = 2'b01,
    GRADE_GOOD      = 2'b10,
    GRADE_EXCELLENT = 2'b11
  } grade_t;

  typedef enum logic [1:0] {
    REGION_ARROW     = 2'd0,
    REGION_TARGET    = 2'd1,
    REGION_INDICATOR = 2'd2
  } region_t;

  function automatic logic [7:0] grade_index(input grade_t g);
    case (g)
      GRADE_EXCELLENT: return GRADE_INDEX_EXCELLENT;
      GRADE_GOOD:      return GRADE_INDEX_GOOD;
      GRADE_BAD:       return GRADE_INDEX_BAD;
      default:         return DEFAULT_INDEX;
    endcase
  endfunction

endpackage

// File: rtl/lane_index_renderer_if.sv
// rtl/lane_index_renderer_if.sv - pixel in / palette index out stream bundle
interface lane_index_renderer_if;
  logic       pixel_valid;
  logic       frame_start;
  logic [7:0] index;
  logic       index_valid;
  logic [9:0] pixel_x;
  logic [8:0] pixel_y;

  modport master (
    output pixel_valid, frame_start,
    input  index, index_valid, pixel_x, pixel_y
  );

  modport slave (
    input  pixel_valid, frame_start,
    output index, index_valid, pixel_x, pixel_y
  );
endinterface

// File: rtl/lane_index_renderer_indicator_hold_timer.sv
// rtl/lane_index_renderer_indicator_hold_timer.sv - per-player grade latch with frame-counted hold
module indicator_hold_timer
  import lane_render_pkg::*;
#(
  parameter int HOLD = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       strobe,
  input  logic [1:0] grade_in,
  input  logic       frame_tick,
  output grade_t     grade_shown
);
  localparam int CNT_W = $clog2(HOLD + 1);

  grade_t             grade_q, grade_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // A strobe on a frame_start cycle reloads and skips that frame's decrement.
  always_comb begin
    grade_d = grade_q;
    count_d = count_q;
    if (strobe) begin
      grade_d = grade_t'(grade_in);
      count_d = CNT_W'(HOLD);
    end else if (frame_tick && count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grade_q <= GRADE_NONE;
      count_q <= '0;
    end else begin
      grade_q <= grade_d;
      count_q <= count_d;
    end
  end

  assign grade_shown = (count_q != '0) ? grade_q : GRADE_NONE;

endmodule

// File: rtl/lane_index_renderer.sv
// rtl/lane_index_renderer.sv - two-stage pixel to palette index renderer with frame snapshot
module lane_index_renderer
  import lane_render_pkg::*;
#(
  parameter int NUM_PLAYERS      = 2,
  parameter int NUM_LANES        = 5,
  parameter int LANE_WIDTH       = 64,
  parameter int STATE_HEIGHT     = 16,
  parameter int NUM_SLOTS        = 26,
  parameter int ARROW_SPAN       = 4,
  parameter int SCREEN_WIDTH     = 640,
  parameter int SCREEN_HEIGHT    = 480,
  parameter int INDICATOR_HEIGHT = 48,
  parameter int INDICATOR_HOLD   = 30
) (
  input  logic                              clock,
  input  logic                              reset,
  lane_index_renderer_if.slave              pix,
  input  logic [NUM_PLAYERS*NUM_SLOTS*3-1:0] arrow_array,
  input  logic [NUM_PLAYERS*2-1:0]          indicator,
  input  logic [NUM_PLAYERS-1:0]            indicator_strobe
);
  localparam int PLAY_H     = SCREEN_HEIGHT - INDICATOR_HEIGHT;
  localparam int TARGET_Y0  = PLAY_H - LANE_WIDTH;
  localparam int PLAYER_W   = NUM_LANES * LANE_WIDTH;
  localparam int SLOT_SHIFT = $clog2(STATE_HEIGHT);
  localparam int P_W        = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int K_W        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int ARR_W      = NUM_PLAYERS * NUM_SLOTS * 3;

  logic [9:0]       cnt_x_q, cnt_x_d;
  logic [8:0]       cnt_y_q, cnt_y_d;
  logic [ARR_W-1:0] shadow_q, shadow_d;

  logic             s1_valid_q, s1_valid_d;
  logic [9:0]       s1_x_q, s1_x_d;
  logic [8:0]       s1_y_q, s1_y_d;
  region_t          s1_region_q, s1_region_d;
  logic [P_W-1:0]   s1_p_q, s1_p_d;
  logic             s1_p_ok_q, s1_p_ok_d;
  logic [K_W-1:0]   s1_k_q, s1_k_d;
  logic [8:0]       s1_slot_q, s1_slot_d;

  logic             out_valid_q, out_valid_d;
  logic [7:0]       index_q, index_d;
  logic [9:0]       px_q, px_d;
  logic [8:0]       py_q, py_d;

  logic             start;
  logic [9:0]       cur_x;
  logic [8:0]       cur_y;
  region_t          region;
  logic [P_W-1:0]   player;
  logic             player_ok;
  logic [K_W-1:0]   lane;
  int               base;
  int               n;
  lane_code_t       lane_code;
  logic [7:0]       lane_colour;
  logic             hit;
  logic [7:0]       rendered;
  grade_t           grade_shown [NUM_PLAYERS];

  // Position counters hold the coordinate the next accepted pixel will take.
  always_comb begin
    start   = pix.pixel_valid & pix.frame_start;
    cur_x   = start ? 10'd0 : cnt_x_q;
    cur_y   = start ? 9'd0 : cnt_y_q;
    cnt_x_d = cnt_x_q;
    cnt_y_d = cnt_y_q;
    if (pix.pixel_valid) begin
      if (cur_x == 10'(SCREEN_WIDTH - 1)) begin
        cnt_x_d = 10'd0;
        cnt_y_d = (cur_y == 9'(SCREEN_HEIGHT - 1)) ? 9'd0 : cur_y + 9'd1;
      end else begin
        cnt_x_d = cur_x + 10'd1;
        cnt_y_d = cur_y;
      end
    end
    shadow_d = start ? arrow_array : shadow_q;
  end

  always_comb begin
    base      = 0;
    player    = '0;
    player_ok = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (int'(cur_x) >= i * PLAYER_W && int'(cur_x) < (i + 1) * PLAYER_W) begin
        player    = P_W'(i);
        player_ok = 1'b1;
        base      = i * PLAYER_W;
      end
    end
    lane = '0;
    for (int l = 1; l < NUM_LANES; l++) begin
      if (int'(cur_x) - base >= l * LANE_WIDTH) lane = K_W'(l);
    end
    if (int'(cur_y) >= PLAY_H)         region = REGION_INDICATOR;
    else if (int'(cur_y) >= TARGET_Y0) region = REGION_TARGET;
    else                               region = REGION_ARROW;

    s1_valid_d  = pix.pixel_valid;
    s1_x_d      = s1_x_q;
    s1_y_d      = s1_y_q;
    s1_region_d = s1_region_q;
    s1_p_d      = s1_p_q;
    s1_p_ok_d   = s1_p_ok_q;
    s1_k_d      = s1_k_q;
    s1_slot_d   = s1_slot_q;
    if (pix.pixel_valid) begin
      s1_x_d      = cur_x;
      s1_y_d      = cur_y;
      s1_region_d = region;
      s1_p_d      = player;
      s1_p_ok_d   = player_ok;
      s1_k_d      = lane;
      s1_slot_d   = cur_y >> SLOT_SHIFT;
    end
  end

  // Slot arithmetic is signed so slots above the top or past the end never alias.
  always_comb begin
    lane_code   = LANE_CODE[s1_k_q];
    lane_colour = LANE_INDEX[s1_k_q];
    hit         = 1'b0;
    n           = 0;
    for (int j = 0; j < ARROW_SPAN; j++) begin
      n = int'(s1_slot_q) - j;
      if (n >= 0 && n < NUM_SLOTS) begin
        if (lane_code != CODE_NONE &&
            shadow_q[(int'(s1_p_q) * NUM_SLOTS + n) * 3 +: 3] == lane_code) begin
          hit = 1'b1;
        end
      end
    end

    rendered = DEFAULT_INDEX;
    if (s1_p_ok_q) begin
      case (s1_region_q)
        REGION_ARROW:     rendered = hit ? lane_colour : DEFAULT_INDEX;
        REGION_TARGET:    rendered = lane_colour;
        REGION_INDICATOR: rendered = grade_index(grade_shown[s1_p_q]);
        default:          rendered = DEFAULT_INDEX;
      endcase
    end

    out_valid_d = s1_valid_q;
    index_d     = index_q;
    px_d        = px_q;
    py_d        = py_q;
    if (s1_valid_q) begin
      index_d = rendered;
      px_d    = s1_x_q;
      py_d    = s1_y_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_x_q     <= '0;
      cnt_y_q     <= '0;
      shadow_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_region_q <= REGION_ARROW;
      s1_p_q      <= '0;
      s1_p_ok_q   <= 1'b0;
      s1_k_q      <= '0;
      s1_slot_q   <= '0;
      out_valid_q <= 1'b0;
      index_q     <= DEFAULT_INDEX;
      px_q        <= '0;
      py_q        <= '0;
    end else begin
      cnt_x_q     <= cnt_x_d;
      cnt_y_q     <= cnt_y_d;
      shadow_q    <= shadow_d;
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_region_q <= s1_region_d;
      s1_p_q      <= s1_p_d;
      s1_p_ok_q   <= s1_p_ok_d;
      s1_k_q      <= s1_k_d;
      s1_slot_q   <= s1_slot_d;
      out_valid_q <= out_valid_d;
      index_q     <= index_d;
      px_q        <= px_d;
      py_q        <= py_d;
    end
  end

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_hold
    indicator_hold_timer #(
      .HOLD(INDICATOR_HOLD)
    ) u_hold (
      .clock      (clock),
      .reset      (reset),
      .strobe     (indicator_strobe[gi]),
      .grade_in   (indicator[gi*2 +: 2]),
      .frame_tick (start),
      .grade_shown(grade_shown[gi])
    );
  end

  assign pix.index       = index_q;
  assign pix.index_valid = out_valid_q;
  assign pix.pixel_x     = px_q;
  assign pix.pixel_y     = py_q;

endmodule

// File: tb/tb_lane_index_renderer.sv
// tb/tb_lane_index_renderer.sv - scoreboard bench on a scaled 80x60 screen with 8-pixel lanes
module tb_lane_index_renderer;
  localparam int NP  = 2;
  localparam int NS  = 26;
  localparam int SW  = 80;
  localparam int SHT = 60;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NP*NS*3-1:0]   arrow_array = '0;
  logic [NP*2-1:0]      indicator = '0;
  logic [NP-1:0]        indicator_strobe = '0;

  lane_index_renderer_if pix();

  lane_index_renderer #(
    .NUM_PLAYERS(NP), .NUM_LANES(5), .LANE_WIDTH(8), .STATE_HEIGHT(2),
    .NUM_SLOTS(NS), .ARROW_SPAN(4), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SHT),
    .INDICATOR_HEIGHT(6), .INDICATOR_HOLD(30)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .pix             (pix),
    .arrow_array     (arrow_array),
    .indicator       (indicator),
    .indicator_strobe(indicator_strobe)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         x;
    int         y;
    bit         chk;
    logic [7:0] idx;
    longint     cyc;
  } exp_t;

  exp_t   sb [$];
  exp_t   mon_e;
  longint cyc = 0;
  int     total = 0;
  int     bad = 0;
  int     bx = 0;
  int     by = 0;
  bit     bubbles = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (pix.index_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid: index_valid=1 at (%0d,%0d) with nothing outstanding", pix.pixel_x, pix.pixel_y);
      end else begin
        mon_e = sb.pop_front();
        total++;
        if (cyc - mon_e.cyc != 2) begin
          bad++;
          $display("FAIL latency: got %0d cycles, want 2 (pixel %0d,%0d)", cyc - mon_e.cyc, mon_e.x, mon_e.y);
        end
        total++;
        if (pix.pixel_x !== 10'(mon_e.x) || pix.pixel_y !== 9'(mon_e.y)) begin
          bad++;
          $display("FAIL coord: got (%0d,%0d), want (%0d,%0d)", pix.pixel_x, pix.pixel_y, mon_e.x, mon_e.y);
        end
        if (mon_e.chk) begin
          total++;
          if (pix.index !== mon_e.idx) begin
            bad++;
            $display("FAIL index at (%0d,%0d): got %0d, want %0d", mon_e.x, mon_e.y, pix.index, mon_e.idx);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    pix.pixel_valid = 1'b0;
    pix.frame_start = 1'b0;
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic drive_pixel(input bit fs, input bit chk, input logic [7:0] exp_idx);
    exp_t e;
    if (fs) begin
      bx = 0; by = 0;
    end
    e.x = bx; e.y = by; e.chk = chk; e.idx = exp_idx; e.cyc = cyc;
    sb.push_back(e);
    pix.pixel_valid = 1'b1;
    pix.frame_start = fs;
    @(posedge clock); #1;
    pix.pixel_valid  = 1'b0;
    pix.frame_start  = 1'b0;
    indicator_strobe = '0;
    if (bx == SW - 1) begin
      bx = 0;
      by = (by == SHT - 1) ? 0 : by + 1;
    end else begin
      bx++;
    end
  endtask

  task automatic advance_to(input int tx, input int ty);
    int guard = 0;
    while (!(bx == tx && by == ty)) begin
      if (bubbles && $urandom_range(0, 3) == 0) idle(1);
      drive_pixel(1'b0, 1'b0, 8'd0);
      guard++;
      if (guard > SW * SHT) begin
        total++; bad++;
        $display("FAIL advance_bound: (%0d,%0d) not reached, at (%0d,%0d)", tx, ty, bx, by);
        return;
      end
    end
  endtask

  task automatic check_at(input int tx, input int ty, input logic [7:0] exp_idx);
    advance_to(tx, ty);
    drive_pixel(1'b0, 1'b1, exp_idx);
  endtask

  task automatic set_slot(input int p, input int s, input logic [2:0] code);
    arrow_array[(p*NS + s)*3 +: 3] = code;
  endtask

  task automatic test_reset;
    pix.pixel_valid = 1'b0;
    pix.frame_start = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    total++; if (pix.index_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", pix.index_valid); end
    total++; if (pix.index !== 8'd0) begin bad++; $display("FAIL reset_index: got %0d want 0", pix.index); end
    total++; if (pix.pixel_x !== 10'd0) begin bad++; $display("FAIL reset_x: got %0d want 0", pix.pixel_x); end
    total++; if (pix.pixel_y !== 9'd0) begin bad++; $display("FAIL reset_y: got %0d want 0", pix.pixel_y); end
    reset = 1'b0;
    bx = 0; by = 0;
    idle(3);
    drive_pixel(1'b1, 1'b1, 8'd0);
    idle(3);
    total++; if (sb.size() != 0) begin bad++; $display("FAIL first_pixel: %0d outputs missing, want 0", sb.size()); end
  endtask

  task automatic test_arrow;
    arrow_array = '0;
    set_slot(0, 10, 3'b010);
    drive_pixel(1'b1, 1'b0, 8'd0);
    check_at(12, 19, 8'd0);
    check_at(12, 20, 8'd4);
    check_at(4, 21, 8'd0);
    check_at(52, 21, 8'd0);
    check_at(12, 23, 8'd4);
    check_at(12, 27, 8'd4);
    check_at(12, 28, 8'd0);
  endtask

  task automatic test_snapshot;
    arrow_array = '0;
    set_slot(0, 10, 3'b010);
    drive_pixel(1'b1, 1'b0, 8'd0);
    check_at(12, 12, 8'd0);
    arrow_array = '0;
    set_slot(0, 15, 3'b010);
    check_at(12, 20, 8'd4);
    check_at(12, 30, 8'd0);
    drive_pixel(1'b1, 1'b0, 8'd0);
    check_at(12, 20, 8'd0);
    check_at(12, 30, 8'd4);
  endtask

  task automatic test_target;
    arrow_array = '0;
    bubbles = 1'b1;
    drive_pixel(1'b1, 1'b0, 8'd0);
    check_at(12, 45, 8'd0);
    check_at(12, 46, 8'd4);
    check_at(41, 50, 8'd8);
    check_at(79, 50, 8'd5);
    check_at(12, 53, 8'd4);
    check_at(12, 54, 8'd0);
    check_at(0, 59, 8'd0);
    bubbles = 1'b0;
  endtask

  task automatic test_slot_edges;
    arrow_array = '0;
    for (int s = 0; s < NS; s++) set_slot(0, s, 3'b001);
    set_slot(1, 25, 3'b110);
    drive_pixel(1'b1, 1'b0, 8'd0);
    check_at(20, 0, 8'd6);
    check_at(60, 0, 8'd0);
    check_at(4, 10, 8'd0);
    check_at(20, 45, 8'd6);
    check_at(44, 45, 8'd0);
    check_at(44, 47, 8'd8);
  endtask

  task automatic test_indicator_hold;
    arrow_array = '0;
    drive_pixel(1'b1, 1'b0, 8'd0);
    advance_to(0, 5);
    indicator = 4'b1100;
    indicator_strobe = 2'b10;
    drive_pixel(1'b0, 1'b0, 8'd0);
    check_at(10, 57, 8'd0);
    check_at(50, 57, 8'd1);
    for (int f = 1; f <= 28; f++) drive_pixel(1'b1, 1'b0, 8'd0);
    drive_pixel(1'b1, 1'b0, 8'd0);
    check_at(50, 57, 8'd1);
    drive_pixel(1'b1, 1'b0, 8'd0);
    check_at(50, 57, 8'd0);
  endtask

  task automatic test_strobe_with_frame_start;
    indicator = 4'b0010;
    indicator_strobe = 2'b01;
    drive_pixel(1'b1, 1'b0, 8'd0);
    check_at(10, 57, 8'd2);
    for (int f = 1; f <= 28; f++) begin
      if (f == 15) begin
        indicator = 4'b0100;
        indicator_strobe = 2'b10;
      end
      drive_pixel(1'b1, 1'b0, 8'd0);
    end
    drive_pixel(1'b1, 1'b0, 8'd0);
    check_at(10, 57, 8'd2);
    check_at(50, 57, 8'd3);
    drive_pixel(1'b1, 1'b0, 8'd0);
    check_at(10, 57, 8'd0);
    check_at(50, 57, 8'd3);
  endtask

  task automatic test_mid_frame_reset;
    arrow_array = '0;
    set_slot(0, 10, 3'b010);
    drive_pixel(1'b1, 1'b0, 8'd0);
    advance_to(5, 3);
    reset = 1'b1;
    @(posedge clock); #1;
    sb.delete();
    total++; if (pix.index_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", pix.index_valid); end
    total++; if (pix.pixel_x !== 10'd0 || pix.pixel_y !== 9'd0) begin bad++; $display("FAIL flush_coord: got (%0d,%0d) want (0,0)", pix.pixel_x, pix.pixel_y); end
    @(posedge clock); #1;
    reset = 1'b0;
    bx = 0; by = 0;
    idle(2);
    check_at(0, 0, 8'd0);
    check_at(12, 20, 8'd0);
    drive_pixel(1'b1, 1'b0, 8'd0);
    check_at(12, 20, 8'd4);
  endtask

  initial begin
    pix.pixel_valid = 1'b0;
    pix.frame_start = 1'b0;
    test_reset();
    test_arrow();
    test_snapshot();
    test_target();
    test_slot_edges();
    test_indicator_hold();
    test_strobe_with_frame_start();
    test_mid_frame_reset();
    idle(4);
    total++; if (sb.size() != 0) begin bad++; $display("FAIL drain: %0d outputs missing, want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
